// File: rtl/stop_com_align_if.sv
// Serial link bundle between the IDLE/COM serializer and the comma aligner.
// master drives the bitstream; slave returns aligned bytes and link status.
interface stop_com_align_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/stop_com_align.sv
// Comma-based byte aligner: bit-slides onto COM_BYTE, requires N_COM aligned commas,
// then delivers every non-comma byte at its boundary until the next reset.
module stop_com_align #(
  parameter logic [7:0]  COM_BYTE = 8'hBC,
  parameter int unsigned N_COM    = 4
) (
  input logic              clk32f,
  input logic              reset,
  stop_com_align_if.slave  io_bus
);

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam logic [2:0] NComW = 3'(N_COM);

  state_e     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bc;
  logic [2:0] r_cc;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_active;

  state_e     w_state_d;
  logic [2:0] w_bc_d;
  logic [2:0] w_cc_d;
  logic [7:0] w_data_d;
  logic       w_valid_d;
  logic       w_active_d;

  logic [7:0] w_win;
  logic       w_is_com;
  logic       w_boundary;
  logic [2:0] w_cc_inc;

  // The window includes the bit being sampled so a byte is acted on in the same edge.
  assign w_win      = {r_sr[6:0], io_bus.data_in};
  assign w_is_com   = (w_win == COM_BYTE);
  assign w_boundary = (r_bc == 3'd7);
  assign w_cc_inc   = r_cc + 3'd1;

  always_comb begin
    w_state_d = r_state;
    w_bc_d    = r_bc;
    w_cc_d    = r_cc;
    w_data_d  = r_data;
    w_valid_d = r_valid;

    case (r_state)
      StSearch: begin
        w_bc_d    = 3'd0;
        w_cc_d    = 3'd0;
        w_data_d  = 8'h00;
        w_valid_d = 1'b0;
        if (w_is_com) begin
          w_cc_d    = 3'd1;
          w_state_d = (NComW == 3'd1) ? StLocked : StAlign;
        end
      end

      StAlign: begin
        w_bc_d    = r_bc + 3'd1;
        w_data_d  = 8'h00;
        w_valid_d = 1'b0;
        if (w_boundary) begin
          if (w_is_com) begin
            w_cc_d = w_cc_inc;
            if (w_cc_inc == NComW) begin
              w_state_d = StLocked;
            end
          end else begin
            // Drop back to bit-sliding; the failed byte is not re-scanned as a whole.
            w_state_d = StSearch;
            w_cc_d    = 3'd0;
            w_bc_d    = 3'd0;
          end
        end
      end

      StLocked: begin
        w_bc_d = r_bc + 3'd1;
        if (w_boundary) begin
          if (w_is_com) begin
            w_valid_d = 1'b0;
          end else begin
            w_data_d  = w_win;
            w_valid_d = 1'b1;
          end
        end
      end

      default: begin
        w_state_d = StSearch;
        w_bc_d    = 3'd0;
        w_cc_d    = 3'd0;
        w_data_d  = 8'h00;
        w_valid_d = 1'b0;
      end
    endcase

    w_active_d = (w_state_d == StLocked);
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state  <= StSearch;
      r_sr     <= 8'h00;
      r_bc     <= 3'd0;
      r_cc     <= 3'd0;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_sr     <= w_win;
      r_bc     <= w_bc_d;
      r_cc     <= w_cc_d;
      r_data   <= w_data_d;
      r_valid  <= w_valid_d;
      r_active <= w_active_d;
    end
  end

  assign io_bus.data_out  = r_data;
  assign io_bus.valid_out = r_valid;
  assign io_bus.active    = r_active;

endmodule

// File: tb/tb_stop_com_align.sv
// Scoreboard bench for stop_com_align: two instances (N_COM=4 and N_COM=1) share one stream;
// each output change is matched against a queued (edge, active, valid, data) expectation.
module tb_stop_com_align;

  typedef struct {
    int         cyc;
    logic       act;
    logic       vld;
    logic [7:0] dat;
  } exp_t;

  logic clk32f;
  logic reset;
  logic data_in;
  int   edge_cnt;
  int   n_checks;
  int   n_fail;
  exp_t q4[$];
  exp_t q1[$];

  stop_com_align_if bus4 ();
  stop_com_align_if bus1 ();

  assign bus4.data_in = data_in;
  assign bus1.data_in = data_in;

  stop_com_align #(.COM_BYTE(8'hBC), .N_COM(4)) u_dut4 (
    .clk32f (clk32f),
    .reset  (reset),
    .io_bus (bus4)
  );

  stop_com_align #(.COM_BYTE(8'hBC), .N_COM(1)) u_dut1 (
    .clk32f (clk32f),
    .reset  (reset),
    .io_bus (bus1)
  );

  initial begin
    clk32f = 1'b0;
    forever #10 clk32f = ~clk32f;
  end

  // Edge index since reset release: bit k of a segment is sampled on edge k.
  always @(posedge clk32f or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic push(input int id, input int cyc, input logic a, input logic v,
                      input logic [7:0] d);
    exp_t e;
    e.cyc = cyc;
    e.act = a;
    e.vld = v;
    e.dat = d;
    if (id == 4) q4.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic check_event(input int id, input logic [9:0] cur);
    exp_t e;
    int   sz;
    n_checks++;
    sz = (id == 4) ? q4.size() : q1.size();
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_change dut%0d edge=%0d got act=%b vld=%b dat=%h required no change",
               id, edge_cnt, cur[9], cur[8], cur[7:0]);
      return;
    end
    e = (id == 4) ? q4.pop_front() : q1.pop_front();
    if (e.cyc != edge_cnt || cur !== {e.act, e.vld, e.dat}) begin
      n_fail++;
      $display("FAIL event dut%0d got edge=%0d act=%b vld=%b dat=%h required edge=%0d act=%b vld=%b dat=%h",
               id, edge_cnt, cur[9], cur[8], cur[7:0], e.cyc, e.act, e.vld, e.dat);
    end
  endtask

  task automatic monitor(input int id);
    logic [9:0] prev;
    logic [9:0] cur;
    prev = '0;
    forever begin
      @(negedge clk32f or negedge reset);
      if (!reset) begin
        #1;
        cur = (id == 4) ? {bus4.active, bus4.valid_out, bus4.data_out}
                        : {bus1.active, bus1.valid_out, bus1.data_out};
        n_checks++;
        if (cur !== 10'd0) begin
          n_fail++;
          $display("FAIL reset_zero dut%0d got act=%b vld=%b dat=%h required all 0",
                   id, cur[9], cur[8], cur[7:0]);
        end
        prev = '0;
      end else begin
        cur = (id == 4) ? {bus4.active, bus4.valid_out, bus4.data_out}
                        : {bus1.active, bus1.valid_out, bus1.data_out};
        if (cur !== prev) begin
          check_event(id, cur);
          prev = cur;
        end
      end
    end
  endtask

  initial monitor(4);
  initial monitor(1);

  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge clk32f);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic finish_run();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL leftover dut4 got pending=%0d required 0", q4.size());
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL leftover dut1 got pending=%0d required 0", q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    data_in  = 1'b0;
    reset    = 1'b1;
    #1 reset = 1'b0;

    // Reset held with random data: every sample must read all zero.
    for (int i = 0; i < 8; i++) begin
      data_in = 1'($urandom);
      @(negedge clk32f);
    end

    // Segment 1: 3 stray bits, 4 commas, then data.
    push(4, 35, 1'b1, 1'b0, 8'h00);
    push(4, 43, 1'b1, 1'b1, 8'hEE);
    push(4, 51, 1'b1, 1'b0, 8'hEE);
    push(4, 59, 1'b1, 1'b1, 8'h12);
    push(4, 67, 1'b1, 1'b0, 8'h12);
    push(4, 75, 1'b1, 1'b1, 8'h5A);
    push(4, 83, 1'b1, 1'b1, 8'h3C);
    push(4, 91, 1'b1, 1'b0, 8'h3C);
    push(1, 11, 1'b1, 1'b0, 8'h00);
    push(1, 43, 1'b1, 1'b1, 8'hEE);
    push(1, 51, 1'b1, 1'b0, 8'hEE);
    push(1, 59, 1'b1, 1'b1, 8'h12);
    push(1, 67, 1'b1, 1'b0, 8'h12);
    push(1, 75, 1'b1, 1'b1, 8'h5A);
    push(1, 83, 1'b1, 1'b1, 8'h3C);
    push(1, 91, 1'b1, 1'b0, 8'h3C);
    reset = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'hEE);
    send_byte(8'hBC);
    send_byte(8'h12);
    send_byte(8'hBC);
    send_byte(8'h5A);
    send_byte(8'h3C);
    send_byte(8'hBC);

    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk32f);

    // Segment 2: broken comma run (2x BC, 55) must restart the count.
    push(4, 56, 1'b1, 1'b0, 8'h00);
    push(4, 64, 1'b1, 1'b1, 8'hA5);
    push(1, 8,  1'b1, 1'b0, 8'h00);
    push(1, 24, 1'b1, 1'b1, 8'h55);
    push(1, 32, 1'b1, 1'b0, 8'h55);
    push(1, 64, 1'b1, 1'b1, 8'hA5);
    reset = 1'b1;
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'hA5);

    // 3 ns reset pulse between edges while locked with valid high.
    @(posedge clk32f);
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    @(negedge clk32f);

    // Segment 3: relock from scratch.
    push(4, 32, 1'b1, 1'b0, 8'h00);
    push(4, 40, 1'b1, 1'b1, 8'h99);
    push(1, 8,  1'b1, 1'b0, 8'h00);
    push(1, 40, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h99);
    for (int i = 0; i < 4; i++) send_bit(1'b0);

    finish_run();
  end

endmodule
